// File: rtl/wbm_arb.sv
// Round-robin arbiter for the DMA engine's shared Wishbone master port.
// Optional build macro WBM_ARB_DESC_PRIO_EN gives descriptor fetch (req 0) arbitration priority.
module wbm_arb #(
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned TO_W      = 8
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic [2:0] req_i,
   output logic [2:0] gnt_o,
   input  logic       wbm_ack_i,
   input  logic       wbm_err_i,
   input  logic       wbm_rty_i,
   output logic       to_o,
   input  logic       to_clear_i,
   output logic [7:0] arb_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2,
      ST_BAD   = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] TO_MAX    = '1;
   localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
   localparam logic [7:0]      BEAT_LAST = 8'(MAX_BURST - 1);

   state_t          state;
   logic [1:0]      last;
   logic [7:0]      beat_cnt;
   logic [TO_W-1:0] to_cnt;
   logic            sticky;
   logic [1:0]      winner;
   logic            cur_req;
   logic            bus_abort;

`ifdef WBM_ARB_DESC_PRIO_EN
   logic [1:0] last_dm;
`endif

   // gnt_o is one-hot, so the granted line's request is a simple mask.
   assign cur_req   = |(req_i & gnt_o);
   assign bus_abort = wbm_err_i | wbm_rty_i;

`ifdef WBM_ARB_DESC_PRIO_EN
   // Req 0 takes every slot following a mover tenure; the movers alternate
   // among themselves, tracked by last_dm since last may hold 0.
   always_comb begin
      winner = 2'd0;
      if (req_i[0] && (last != 2'd0 || req_i[2:1] == 2'b00)) begin
         winner = 2'd0;
      end else if (req_i[1] && req_i[2]) begin
         winner = (last_dm == 2'd1) ? 2'd2 : 2'd1;
      end else if (req_i[1]) begin
         winner = 2'd1;
      end else if (req_i[2]) begin
         winner = 2'd2;
      end
   end
`else
   logic [1:0] nxt1;
   logic [1:0] nxt2;

   always_comb begin
      nxt1   = (last == 2'd2) ? 2'd0 : last + 2'd1;
      nxt2   = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;
      winner = last;
      if (req_i[nxt2]) begin
         winner = nxt2;
      end
      if (req_i[nxt1]) begin
         winner = nxt1;
      end
   end
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state    <= ST_IDLE;
         gnt_o    <= 3'b000;
         to_o     <= 1'b0;
         last     <= 2'd2;
         beat_cnt <= 8'd0;
         to_cnt   <= '0;
         sticky   <= 1'b0;
`ifdef WBM_ARB_DESC_PRIO_EN
         last_dm  <= 2'd2;
`endif
      end else begin
         to_o <= 1'b0;
         // A timeout raised below overrides this clear in the same cycle.
         if (to_clear_i) begin
            sticky <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (|req_i) begin
                  gnt_o    <= 3'b001 << winner;
                  last     <= winner;
                  beat_cnt <= 8'd0;
                  to_cnt   <= '0;
                  state    <= ST_GRANT;
`ifdef WBM_ARB_DESC_PRIO_EN
                  if (winner != 2'd0) begin
                     last_dm <= winner;
                  end
`endif
               end else begin
                  gnt_o <= 3'b000;
               end
            end
            ST_GRANT: begin
               if (bus_abort) begin
                  gnt_o <= 3'b000;
                  state <= ST_GAP;
               end else if (wbm_ack_i) begin
                  beat_cnt <= beat_cnt + 8'd1;
                  to_cnt   <= '0;
                  if (beat_cnt == BEAT_LAST || !cur_req) begin
                     gnt_o <= 3'b000;
                     state <= ST_GAP;
                  end
               end else if (!cur_req) begin
                  gnt_o <= 3'b000;
                  state <= ST_GAP;
               end else if (to_cnt == TO_MAX) begin
                  gnt_o  <= 3'b000;
                  state  <= ST_GAP;
                  to_o   <= 1'b1;
                  sticky <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_ONE;
               end
            end
            ST_GAP: begin
               gnt_o <= 3'b000;
               state <= ST_IDLE;
            end
            default: begin
               gnt_o <= 3'b000;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign arb_state_o = {sticky, last, gnt_o, state};

endmodule

// File: tb/tb_wbm_arb.sv
// Self-checking bench for wbm_arb: directed scenarios plus randomized traffic
// compared each cycle against a tenure-level reference model.
module tb_wbm_arb;

   localparam int MAX_BURST = 16;
   localparam int TO_W      = 8;
   localparam int TO_LIMIT  = (1 << TO_W) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = 3'b000;
   logic [2:0] gnt;
   logic       ack = 1'b0;
   logic       err = 1'b0;
   logic       rty = 1'b0;
   logic       to_p;
   logic       to_clear = 1'b0;
   logic [7:0] st;

   int checks   = 0;
   int failures = 0;

   // Reference model: who owns the bus, and whether we are in the post-release gap.
   int m_owner;
   int m_last;
   int m_last_dm;
   int m_beats;
   int m_quiet;
   bit m_gap;
   bit m_sticky;
   bit m_to;

   always #5 clk = ~clk;

   wbm_arb #(.MAX_BURST(MAX_BURST), .TO_W(TO_W)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .req_i       (req),
      .gnt_o       (gnt),
      .wbm_ack_i   (ack),
      .wbm_err_i   (err),
      .wbm_rty_i   (rty),
      .to_o        (to_p),
      .to_clear_i  (to_clear),
      .arb_state_o (st)
   );

   function automatic void model_reset();
      m_owner   = -1;
      m_gap     = 1'b0;
      m_last    = 2;
      m_last_dm = 2;
      m_beats   = 0;
      m_quiet   = 0;
      m_sticky  = 1'b0;
      m_to      = 1'b0;
   endfunction

   function automatic int pick();
`ifdef WBM_ARB_DESC_PRIO_EN
      int first;
      if (req[0] && (m_last != 0 || req[2:1] == 2'b00)) return 0;
      first = (m_last_dm == 1) ? 2 : 1;
      if (req[first]) return first;
      if (req[3 - first]) return 3 - first;
      return -1;
`else
      for (int k = 1; k <= 3; k++) begin
         int i;
         i = (m_last + k) % 3;
         if (req[i]) return i;
      end
      return -1;
`endif
   endfunction

   function automatic void release_bus();
      m_owner = -1;
      m_gap   = 1'b1;
   endfunction

   function automatic void model_step();
      bit timeout_now;
      int w;
      timeout_now = 1'b0;
      m_to        = 1'b0;
      if (m_owner >= 0) begin
         if (err || rty) begin
            release_bus();
         end else if (ack) begin
            m_beats++;
            m_quiet = 0;
            if (m_beats == MAX_BURST || !req[m_owner]) release_bus();
         end else if (!req[m_owner]) begin
            release_bus();
         end else if (m_quiet == TO_LIMIT) begin
            release_bus();
            timeout_now = 1'b1;
            m_to        = 1'b1;
         end else begin
            m_quiet++;
         end
      end else if (m_gap) begin
         m_gap = 1'b0;
      end else begin
         w = pick();
         if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            if (w != 0) m_last_dm = w;
            m_beats = 0;
            m_quiet = 0;
         end
      end
      if (timeout_now) m_sticky = 1'b1;
      else if (to_clear) m_sticky = 1'b0;
   endfunction

   function automatic logic [11:0] exp_out();
      logic [2:0] g;
      logic [1:0] code;
      g    = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
      code = (m_owner >= 0) ? 2'd1 : (m_gap ? 2'd2 : 2'd0);
      return {m_to, g, m_sticky, 2'(m_last), g, code};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      req = 3'b000; ack = 1'b0; err = 1'b0; rty = 1'b0; to_clear = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (gnt !== 3'b000) begin
         failures++; $display("FAIL reset_gnt got=%b exp=000", gnt);
      end
      checks++;
      if (to_p !== 1'b0) begin
         failures++; $display("FAIL reset_to got=%b exp=0", to_p);
      end
      checks++;
      if (st !== 8'h40) begin
         failures++; $display("FAIL reset_state got=%h exp=40", st);
      end
   endtask

   task automatic test_round_robin();
      int exp_idx[$];
      int n = 0;
      int budget = 0;
      logic [2:0] prev_g = 3'b000;
`ifdef WBM_ARB_DESC_PRIO_EN
      exp_idx.push_back(0); exp_idx.push_back(1); exp_idx.push_back(0);
      exp_idx.push_back(2); exp_idx.push_back(0);
`else
      exp_idx.push_back(0); exp_idx.push_back(1); exp_idx.push_back(2);
      exp_idx.push_back(0);
`endif
      apply_reset();
      req = 3'b111;
      while (n < exp_idx.size() && budget < 400) begin
         ack = (m_owner >= 0);
         tick();
         budget++;
         checks++;
         if ({to_p, gnt, st} !== exp_out()) begin
            failures++; $display("FAIL rr_cycle t=%0t got=%h exp=%h", $time, {to_p, gnt, st}, exp_out());
         end
         if (gnt !== 3'b000 && prev_g === 3'b000) begin
            checks++;
            if (gnt !== 3'(1 << exp_idx[n]) || st[6:5] !== 2'(exp_idx[n])) begin
               failures++;
               $display("FAIL rr_order grant%0d got gnt=%b last=%0d exp gnt=%b last=%0d",
                        n, gnt, st[6:5], 3'(1 << exp_idx[n]), exp_idx[n]);
            end
            n++;
         end
         prev_g = gnt;
      end
      if (n < exp_idx.size()) begin
         checks++; failures++;
         $display("FAIL rr_budget got %0d grants exp %0d", n, exp_idx.size());
      end
      req = 3'b000; ack = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_burst_cap();
      int n = 0;
      int cyc = 0;
      apply_reset();
      req = 3'b010;
      tick();
      checks++;
      if (gnt !== 3'b010) begin
         failures++; $display("FAIL cap_first_grant got=%b exp=010", gnt);
      end
      while (gnt === 3'b010 && cyc < 100) begin
         ack = 1'b1;
         n++;
         tick();
         cyc++;
         checks++;
         if ({to_p, gnt, st} !== exp_out()) begin
            failures++; $display("FAIL cap_cycle t=%0t got=%h exp=%h", $time, {to_p, gnt, st}, exp_out());
         end
      end
      ack = 1'b0;
      checks++;
      if (n != MAX_BURST) begin
         failures++; $display("FAIL cap_beats got=%0d exp=%0d", n, MAX_BURST);
      end
      checks++;
      if (gnt !== 3'b000 || st[1:0] !== 2'd2) begin
         failures++; $display("FAIL cap_gap got gnt=%b state=%0d exp gnt=000 state=2", gnt, st[1:0]);
      end
      tick();
      checks++;
      if (gnt !== 3'b000 || st[1:0] !== 2'd0) begin
         failures++; $display("FAIL cap_idle got gnt=%b state=%0d exp gnt=000 state=0", gnt, st[1:0]);
      end
      tick();
      checks++;
      if (gnt !== 3'b010 || st[1:0] !== 2'd1) begin
         failures++; $display("FAIL cap_regrant got gnt=%b state=%0d exp gnt=010 state=1", gnt, st[1:0]);
      end
      req = 3'b000;
      repeat (4) tick();
   endtask

   task automatic test_timeout();
      for (int run = 0; run < 2; run++) begin
         int n = 0;
         bit seen = 1'b0;
         apply_reset();
         req = 3'b100;
         tick();
         checks++;
         if (gnt !== 3'b100) begin
            failures++; $display("FAIL to_grant run%0d got=%b exp=100", run, gnt);
         end
         // Second run holds the clear high so the set must win on the expiry edge.
         to_clear = (run == 1);
         for (int c = 0; c < 400 && !seen; c++) begin
            if (gnt === 3'b100) n++;
            tick();
            checks++;
            if ({to_p, gnt, st} !== exp_out()) begin
               failures++; $display("FAIL to_cycle t=%0t got=%h exp=%h", $time, {to_p, gnt, st}, exp_out());
            end
            if (to_p === 1'b1) seen = 1'b1;
         end
         to_clear = 1'b0;
         checks++;
         if (!seen) begin
            failures++; $display("FAIL to_pulse run%0d got none exp pulse", run);
         end
         checks++;
         if (n < TO_LIMIT) begin
            failures++; $display("FAIL to_quiet run%0d got %0d granted cycles exp >= %0d", run, n, TO_LIMIT);
         end
         checks++;
         if (gnt !== 3'b000 || st[7] !== 1'b1) begin
            failures++; $display("FAIL to_release run%0d got gnt=%b sticky=%b exp gnt=000 sticky=1", run, gnt, st[7]);
         end
         req = 3'b000;
         tick();
         checks++;
         if (to_p !== 1'b0 || st[7] !== 1'b1) begin
            failures++; $display("FAIL to_one_cycle run%0d got to=%b sticky=%b exp to=0 sticky=1", run, to_p, st[7]);
         end
         to_clear = 1'b1;
         tick();
         to_clear = 1'b0;
         checks++;
         if (st[7] !== 1'b0) begin
            failures++; $display("FAIL to_clear run%0d got sticky=%b exp 0", run, st[7]);
         end
      end
   endtask

   task automatic test_err_ack();
      int n = 0;
      int cyc = 0;
      apply_reset();
      req = 3'b010;
      tick();
      ack = 1'b1;
      repeat (3) tick();
      err = 1'b1;
      tick();
      err = 1'b0; ack = 1'b0;
      checks++;
      if (gnt !== 3'b000 || st[1:0] !== 2'd2 || to_p !== 1'b0) begin
         failures++; $display("FAIL err_ack got gnt=%b state=%0d to=%b exp gnt=000 state=2 to=0", gnt, st[1:0], to_p);
      end
      repeat (2) tick();
      checks++;
      if (gnt !== 3'b010) begin
         failures++; $display("FAIL err_regrant got=%b exp=010", gnt);
      end
      // A fresh tenure must get the full burst, with no carry-over from before.
      while (gnt === 3'b010 && cyc < 100) begin
         ack = 1'b1;
         n++;
         tick();
         cyc++;
      end
      ack = 1'b0;
      checks++;
      if (n != MAX_BURST) begin
         failures++; $display("FAIL err_fresh_burst got=%0d exp=%0d", n, MAX_BURST);
      end
      repeat (2) tick();
      rty = 1'b1;
      tick();
      rty = 1'b0;
      checks++;
      if ({to_p, gnt, st} !== exp_out() || gnt !== 3'b000) begin
         failures++; $display("FAIL rty_release got=%h exp=%h", {to_p, gnt, st}, exp_out());
      end
      req = 3'b000;
      repeat (4) tick();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req = 3'b100;
      tick();
      ack = 1'b1;
      repeat (3) tick();
      checks++;
      if (gnt !== 3'b100) begin
         failures++; $display("FAIL mid_pre got=%b exp=100", gnt);
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (gnt !== 3'b000 || st !== 8'h40 || to_p !== 1'b0) begin
         failures++; $display("FAIL mid_async got gnt=%b state=%h exp gnt=000 state=40", gnt, st);
      end
      ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      req = 3'b111;
      tick();
      checks++;
      if (gnt !== 3'b001) begin
         failures++; $display("FAIL mid_first_grant got=%b exp=001", gnt);
      end
      req = 3'b000;
      repeat (4) tick();
   endtask

   task automatic test_random();
      int ack_pct = 50;
      int req_pct = 5;
      apply_reset();
      for (int c = 0; c < 6000; c++) begin
         if (c % 1000 == 0) begin
            case ((c / 1000) % 3)
               0:       begin ack_pct = 60; req_pct = 5;  end
               1:       begin ack_pct = 0;  req_pct = 0;  end
               default: begin ack_pct = 95; req_pct = 10; end
            endcase
         end
         if (req_pct == 0) begin
            if ($urandom_range(0, 999) < 2) req = 3'($urandom_range(0, 7));
         end else if ($urandom_range(0, 99) < req_pct) begin
            req = 3'($urandom_range(0, 7));
         end
         ack      = ($urandom_range(0, 99) < ack_pct);
         err      = (ack_pct != 0) && ($urandom_range(0, 99) < 2);
         rty      = (ack_pct != 0) && ($urandom_range(0, 99) < 2);
         to_clear = ($urandom_range(0, 99) < 3);
         tick();
         checks++;
         if ({to_p, gnt, st} !== exp_out()) begin
            failures++; $display("FAIL rand_cycle%0d got=%h exp=%h", c, {to_p, gnt, st}, exp_out());
         end
      end
      req = 3'b000; ack = 1'b0; err = 1'b0; rty = 1'b0; to_clear = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_round_robin();
      test_burst_cap();
      test_timeout();
      test_err_ack();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout simulation did not finish t=%0t", $time);
      $fatal(1, "global timeout");
   end

endmodule
